// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC job scheduler.
// Engine geometry and the scheduler FSM encoding.
package cordic_pkg;
  localparam int FP_W                = 32;
  localparam int ENG_ITERS_PER_CYCLE = 4;
  localparam int ENG_CYCLES          = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request strictly after ptr wins,
// returned as a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);
  localparam int PW = $clog2(NREQ);

  logic          found;
  logic [PW-1:0] jj;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    jj    = '0;
    for (int k = 0; k < NREQ; k++) begin
      jj = PW'((int'(ptr) + 1 + k) % NREQ);
      if (!found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        idx     = IDW'(jj);
      end
    end
  end
endmodule

// File: rtl/cordic_job_scheduler.sv
// Shares one iterative CORDIC cosine engine between NREQ requesters,
// with round-robin grant, a one-entry response buffer and a watchdog.
module cordic_job_scheduler
  import cordic_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic                 clk_en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [FP_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 eng_start,
  output logic [FP_W-1:0]      eng_dataa,
  input  logic                 eng_done,
  input  logic [FP_W-1:0]      eng_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [FP_W-1:0]      rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic                 busy
);
  localparam int WW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic            start_q, start_d;
  logic [FP_W-1:0] dataa_q, dataa_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            rvld_q, rvld_d;
  logic [FP_W-1:0] rdata_q, rdata_d;
  logic [IDW-1:0]  rid_q, rid_d;
  logic            rerr_q, rerr_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic [FP_W-1:0] ops [NREQ];
  logic            accept;

  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign ops[i] = req_data[FP_W*i +: FP_W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (gnt),
    .idx (gidx)
  );

  // A grant is only real on a cycle the registers will actually advance.
  assign accept    = clk_en && !aclr && (state_q == IDLE) && (|req_valid);
  assign req_ready = accept ? gnt : '0;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    dataa_d = dataa_q;
    id_d    = id_q;
    rr_d    = rr_q;
    wdog_d  = wdog_q;
    rvld_d  = rvld_q;
    rdata_d = rdata_q;
    rid_d   = rid_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dataa_d = ops[gidx];
          id_d    = gidx;
          rr_d    = gidx;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          rdata_d = eng_result;
          rid_d   = id_q;
          rerr_d  = 1'b0;
          rvld_d  = 1'b1;
          state_d = RESP;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          rid_d   = id_q;
          rerr_d  = 1'b1;
          rvld_d  = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      dataa_q <= '0;
      id_q    <= '0;
      rr_q    <= IDW'(NREQ - 1);
      wdog_q  <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      rid_q   <= '0;
      rerr_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      start_q <= start_d;
      dataa_q <= dataa_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      wdog_q  <= wdog_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
      rerr_q  <= rerr_d;
    end
  end

  assign eng_start = start_q;
  assign eng_dataa = dataa_q;
  assign rsp_valid = rvld_q;
  assign rsp_data  = rdata_q;
  assign rsp_id    = rid_q;
  assign rsp_err   = rerr_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_cordic_job_scheduler.sv
// Scoreboard bench for cordic_job_scheduler with a behavioural
// cosine engine, round-robin grant model and randomized traffic.
module tb_cordic_job_scheduler;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              aclr, clk_en;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [32*NREQ-1:0] req_data;
  logic              eng_start, eng_done;
  logic [31:0]       eng_dataa, eng_result;
  logic              rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;

  cordic_job_scheduler #(
    .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .aclr(aclr), .clk_en(clk_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_start(eng_start), .eng_dataa(eng_dataa),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic real fp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] rand_op();
    return r2fp(1.5 * real'($urandom_range(0, 1000)) / 1000.0);
  endfunction

  // Engine: result ready ENG_CYCLES enabled cycles after start, done sticks.
  logic        hang = 1'b0;
  logic        force_done = 1'b0;
  logic        done_r = 1'b0;
  logic [31:0] eres = '0;
  int          ecnt = 0;
  always @(posedge clock) begin
    if (clk_en) begin
      if (eng_start) begin
        ecnt   <= 3;
        done_r <= 1'b0;
        eres   <= r2fp($cos(fp2r(eng_dataa)));
      end else if (ecnt > 0) begin
        ecnt <= ecnt - 1;
        if (ecnt == 1 && !hang) done_r <= 1'b1;
      end
    end
  end
  assign eng_done   = done_r | force_done;
  assign eng_result = eres;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic           err;
    int             lat;
    int             gcyc;
  } exp_t;

  exp_t        q[$];
  logic        busy_m = 1'b0;
  int          last_g = NREQ - 1;
  logic        seen = 1'b0;
  int          exp_lat = 6;
  logic        chk_gap = 1'b0;
  logic        prev_ok = 1'b0;
  int          prev_gcyc = 0;
  int          resp_cnt = 0;
  logic [31:0] last_data = '0;
  logic [IDW-1:0] last_id = '0;
  logic        last_err = 1'b0;

  always @(negedge clock) begin
    logic was_busy;
    int g;
    exp_t e;
    if (aclr) begin
      q.delete();
      busy_m = 1'b0;
      last_g = NREQ - 1;
      seen = 1'b0;
    end else begin
      was_busy = busy_m;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_spurious", 1, 0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("rsp_latency", cyc - q[0].gcyc, q[0].lat);
          end
          chk("rsp_id", rsp_id, q[0].id);
          chk("rsp_data", rsp_data, q[0].data);
          chk("rsp_err", rsp_err, q[0].err);
          chk("start_while_rsp", eng_start, 0);
          if (rsp_ready && clk_en) begin
            e = q.pop_front();
            last_data = rsp_data;
            last_id = rsp_id;
            last_err = rsp_err;
            busy_m = 1'b0;
            seen = 1'b0;
            resp_cnt++;
          end
        end
      end
      if (!was_busy && clk_en && (|req_valid)) begin
        g = -1;
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && req_valid[(last_g + k) % NREQ]) g = (last_g + k) % NREQ;
        chk("grant", req_ready, 64'(1 << g));
        if (chk_gap && prev_ok) chk("grant_gap", cyc - prev_gcyc, 7);
        prev_ok = chk_gap;
        prev_gcyc = cyc;
        e.id = IDW'(g);
        e.err = hang;
        e.data = hang ? 32'd0 : r2fp($cos(fp2r(req_data[32*g +: 32])));
        e.lat = exp_lat;
        e.gcyc = cyc;
        q.push_back(e);
        busy_m = 1'b1;
        last_g = g;
      end else begin
        chk("req_ready_idle", req_ready, 0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    step();
    while ((busy_m || q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: got busy expected idle within 300 cycles");
    end
    chk("busy_after_job", busy, 0);
  endtask

  initial begin
    int n;
    int base;
    int diff;
    aclr = 1'b1; clk_en = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    step();
    step();
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_dataa", eng_dataa, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    aclr = 1'b0;
    step();

    req_data[31:0] = 32'h3F80_0000;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    wait_idle();
    checks++;
    diff = int'(last_data) - int'(32'h3F0A_5140);
    if (diff < -64 || diff > 64) begin
      failures++;
      $display("FAIL cos_1p0: got %0h expected ~3f0a5140", last_data);
    end
    chk("cos_1p0_id", last_id, 0);
    chk("cos_1p0_err", last_err, 0);

    force_done = 1'b1;
    step();
    req_data[95:64] = rand_op();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    force_done = 1'b0;
    wait_idle();

    hang = 1'b1;
    exp_lat = 2 + TIMEOUT;
    req_data[63:32] = rand_op();
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    wait_idle();
    hang = 1'b0;

    exp_lat = 9;
    req_data[127:96] = rand_op();
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();
    step();
    clk_en = 1'b0;
    repeat (3) step();
    clk_en = 1'b1;
    wait_idle();
    exp_lat = 6;

    rsp_ready = 1'b0;
    req_data[31:0] = rand_op();
    req_valid = 4'b0001;
    step();
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    req_valid = 4'b1111;
    repeat (20) step();
    rsp_ready = 1'b1;
    step();
    step();
    req_valid = '0;
    wait_idle();

    req_data[95:64] = rand_op();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    step();
    aclr = 1'b1;
    step();
    aclr = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    req_valid = 4'b1111;
    step();
    req_valid = '0;
    wait_idle();
    chk("rst_next_grant_id", last_id, 0);

    chk_gap = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = rand_op();
    req_valid = 4'b1111;
    base = resp_cnt;
    n = 0;
    while (resp_cnt < base + 8 && n < 100) begin
      step();
      n++;
    end
    chk("fair_jobs_done", resp_cnt - base >= 8, 1);
    req_valid = '0;
    chk_gap = 1'b0;
    wait_idle();

    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = rand_op();
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
